// File: rtl/debug_mem_arb_pkg.sv
// debug_mem_arb_pkg: state/grant encodings and default starvation limit for debug_mem_arbiter
package debug_mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, OWN_CORE = 2'b01, OWN_DBG = 2'b10} arb_state_t;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CORE = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/debug_mem_arb_starve_cnt.sv
// debug_mem_arb_starve_cnt: saturating count of debug wins over a waiting core
module debug_mem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [3:0] o_cnt
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != 4'(LIMIT)) r_cnt <= r_cnt + 4'd1;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/debug_mem_arbiter.sv
// debug_mem_arbiter: core/debugger arbiter for the shared byte-wide memory port.
// DEBUG_MEM_ARB_STARVE_GUARD_EN adds a starvation guard forcing the core in after STARVE_LIMIT debug wins.
module debug_mem_arbiter
    import debug_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_halt,
    input  logic              coreRead,
    input  logic              coreWrite,
    input  logic [ADDR_W-1:0] coreAddr,
    input  logic [7:0]        coreDataOut,
    output logic [7:0]        coreDataIn,
    output logic              coreReady,
    input  logic              dbgRead,
    input  logic              dbgWrite,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [7:0]        dbgDataOut,
    output logic [7:0]        dbgDataIn,
    output logic              dbgReady,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memDataOut,
    input  logic [7:0]        memDataIn,
    input  logic              memReady,
    output logic              grant_core,
    output logic              grant_dbg,
    output logic              proto_err
);
    arb_state_t        r_state;
    logic              r_proto_err;
    logic              w_core_req, w_dbg_req, w_force_core, w_pick_dbg, w_pick_core;
    logic              w_own_core, w_own_dbg, w_rd, w_wr;
    logic [3:0]        w_starve_cnt;

    assign w_core_req  = (coreRead | coreWrite) & ~core_halt;
    assign w_dbg_req   = dbgRead | dbgWrite;
    assign w_pick_dbg  = w_dbg_req & ~w_force_core;
    assign w_pick_core = w_core_req & ~w_pick_dbg;

`ifdef DEBUG_MEM_ARB_STARVE_GUARD_EN
    debug_mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_inc (r_state == IDLE && w_pick_dbg && w_core_req),
        .i_clr (core_halt || (r_state == IDLE && w_pick_core)),
        .o_cnt (w_starve_cnt)
    );
`else
    assign w_starve_cnt = 4'd0;
`endif
    // Limit is at least 1, so a counter tied to 0 never forces the core in
    assign w_force_core = w_core_req && (w_starve_cnt == 4'(STARVE_LIMIT));

    assign w_own_core = (r_state == OWN_CORE);
    assign w_own_dbg  = (r_state == OWN_DBG);
    assign {grant_dbg, grant_core} = w_own_dbg ? GRANT_DBG : w_own_core ? GRANT_CORE : GRANT_NONE;

    assign w_rd       = (w_own_core & coreRead) | (w_own_dbg & dbgRead);
    assign w_wr       = (w_own_core & coreWrite) | (w_own_dbg & dbgWrite);
    assign memRead    = w_rd & ~w_wr;
    assign memWrite   = w_wr;
    assign memAddr    = w_own_core ? coreAddr : w_own_dbg ? dbgAddr : '0;
    assign memDataOut = w_own_core ? coreDataOut : w_own_dbg ? dbgDataOut : '0;
    assign coreReady  = w_own_core & memReady;
    assign dbgReady   = w_own_dbg & memReady;
    assign coreDataIn = w_own_core ? memDataIn : '0;
    assign dbgDataIn  = w_own_dbg ? memDataIn : '0;
    assign proto_err  = r_proto_err;

    // Ownership ends only once the owner drops both strobes; IDLE always lasts at least a cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state     <= IDLE;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | (w_rd & w_wr);
            if (r_state == IDLE) r_state <= w_pick_dbg ? OWN_DBG : w_pick_core ? OWN_CORE : IDLE;
            else if (!(w_rd | w_wr)) r_state <= IDLE;
        end
endmodule
